// File: rtl/counter_ctrl.sv
// counter_ctrl: sequences an external counter through clear/count/match cycles.
// Register map: 0 CTRL, 1 PRESCALE, 2 COMPARE, 3 STATUS (8-bit data path).
// Optional prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN; without it
// every RUN cycle is a tick and PRESCALE reads as zero.
module counter_ctrl #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             busy,
  output logic             irq
);

  typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

  state_e             state_q, state_d;
  logic               periodic_q, irq_en_q, match_q, match_d, match_set;
  logic [CNT_W-1:0]   compare_q;
  logic [PRE_W-1:0]   prescale_val;
  logic               tick;

  logic wr_ctrl, wr_pre, wr_cmp, wr_stat;
  logic start_req, stop_req;

  assign wr_ctrl   = cfg_we && (cfg_addr == 2'd0);
  assign wr_pre    = cfg_we && (cfg_addr == 2'd1);
  assign wr_cmp    = cfg_we && (cfg_addr == 2'd2);
  assign wr_stat   = cfg_we && (cfg_addr == 2'd3);
  assign start_req = wr_ctrl && cfg_wdata[0];
  assign stop_req  = wr_ctrl && cfg_wdata[2];

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] prescale_q, pre_cnt_q, pre_cnt_d;

  assign prescale_val = prescale_q;
  // Exact equality only: a counter already past a shrunk PRESCALE runs on to wrap.
  assign tick = (pre_cnt_q == prescale_q);

  // Prescale counter: zeroed in CLEAR, free-running with wrap-on-tick in RUN.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (state_q == StClear) begin
      pre_cnt_d = '0;
    end else if (state_q == StRun) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    end
  end

  // Prescale register and counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      if (wr_pre) prescale_q <= PRE_W'(cfg_wdata);
    end
  end
`else
  assign prescale_val = '0;
  assign tick         = 1'b1;
`endif

  // Next state and counter strobes; stop beats start, both beat normal sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_enable = 1'b0;
    cnt_clear  = 1'b0;
    match_set  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StClear: begin
        cnt_clear = 1'b1;
        state_d   = StRun;
      end
      StRun: begin
        if (tick) begin
          if (cnt_value == compare_q) begin
            cnt_clear = 1'b1;
            match_set = 1'b1;
            if (!periodic_q) state_d = StIdle;
          end else begin
            // Freeze the count at the value seen when stop is written.
            cnt_enable = !stop_req;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (stop_req) begin
      state_d = StIdle;
    end else if (start_req) begin
      state_d = StClear;
    end
  end

  // Match flag: a new match outranks a simultaneous software clear.
  always_comb begin
    match_d = match_q;
    if (wr_stat && cfg_wdata[1]) match_d = 1'b0;
    if (match_set) match_d = 1'b1;
  end

  // Control state and configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      match_q    <= 1'b0;
      compare_q  <= '1;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      if (wr_ctrl) begin
        periodic_q <= cfg_wdata[1];
        irq_en_q   <= cfg_wdata[3];
      end
      if (wr_cmp) compare_q <= CNT_W'(cfg_wdata);
    end
  end

  assign busy = (state_q == StClear) || (state_q == StRun);
  assign irq  = match_q && irq_en_q;

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = 8'h00;
    unique case (cfg_addr)
      2'd0: cfg_rdata = {4'b0, irq_en_q, 1'b0, periodic_q, 1'b0};
      2'd1: cfg_rdata = 8'(prescale_val);
      2'd2: cfg_rdata = 8'(compare_q);
      2'd3: cfg_rdata = {6'b0, match_q, busy};
      default: cfg_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a simple external counter model.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'h00;
  logic [7:0] cfg_rdata;
  logic [7:0] cnt = 8'h00;
  logic       cnt_enable, cnt_clear, busy, irq;

  int n_cmp = 0;
  int n_err = 0;

  counter_ctrl #(.CNT_W(8), .PRE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cnt_value  (cnt),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // External counter driven by the DUT strobes.
  always @(posedge clk) begin
    if (cnt_clear) cnt <= 8'h00;
    else if (cnt_enable) cnt <= cnt + 8'h01;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    check(tag, {24'h0, cfg_rdata}, {24'h0, exp});
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_en", cnt_enable, 0);
    check("rst_clr", cnt_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    chk_rd("rst_ctrl", 2'd0, 8'h00);
    chk_rd("rst_pre", 2'd1, 8'h00);
    chk_rd("rst_cmp", 2'd2, 8'hFF);
    chk_rd("rst_stat", 2'd3, 8'h00);
    reset = 1'b1;
    step();

    // One-shot, COMPARE=3
    wr(2'd2, 8'd3);
    wr(2'd0, 8'h01);
    check("os_clear", cnt_clear, 1);
    check("os_clear_en", cnt_enable, 0);
    check("os_clear_busy", busy, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      check("os_val", cnt, i);
      check("os_en", cnt_enable, 1);
      check("os_noclr", cnt_clear, 0);
      step();
    end
    check("os_match_val", cnt, 3);
    check("os_match_clr", cnt_clear, 1);
    check("os_match_en", cnt_enable, 0);
    step();
    check("os_idle_busy", busy, 0);
    check("os_idle_cnt", cnt, 0);
    check("os_irq_off", irq, 0);
    chk_rd("os_stat", 2'd3, 8'h02);
    wr(2'd3, 8'h02);
    chk_rd("os_stat_clr", 2'd3, 8'h00);

`ifdef COUNTER_CTRL_PRESCALE_EN
    // PRESCALE=2, COMPARE=1, periodic with irq
    wr(2'd1, 8'd2);
    chk_rd("ps_pre_rd", 2'd1, 8'd2);
    wr(2'd2, 8'd1);
    wr(2'd0, 8'h0B);
    check("ps_clear", cnt_clear, 1);
    for (int k = 0; k < 12; k++) begin
      step();
      check("ps_en", cnt_enable, (k % 6) == 2);
      check("ps_clr", cnt_clear, (k % 6) == 5);
      check("ps_irq", irq, k >= 6);
    end
    step();
    wr(2'd3, 8'h02);
    check("ps_irq_clr", irq, 0);
    wr(2'd0, 8'h04);
    check("ps_stop_busy", busy, 0);
    wr(2'd1, 8'd0);
`else
    // No prescaler: PRESCALE reads 0, period = COMPARE+1
    wr(2'd1, 8'd5);
    chk_rd("np_pre_rd", 2'd1, 8'h00);
    wr(2'd2, 8'd2);
    wr(2'd0, 8'h03);
    check("np_clear", cnt_clear, 1);
    for (int k = 0; k < 9; k++) begin
      step();
      check("np_en", cnt_enable, (k % 3) != 2);
      check("np_clr", cnt_clear, (k % 3) == 2);
    end
    wr(2'd0, 8'h04);
    check("np_stop_busy", busy, 0);
    chk_rd("np_stat", 2'd3, 8'h02);
    wr(2'd3, 8'h02);
    chk_rd("np_stat_clr", 2'd3, 8'h00);
`endif

    // Stop mid-RUN at cnt_value=5
    wr(2'd2, 8'd10);
    wr(2'd0, 8'h01);
    step();
    repeat (5) step();
    check("stop_at5", cnt, 5);
    wr(2'd0, 8'h04);
    check("stop_en", cnt_enable, 0);
    check("stop_busy", busy, 0);
    check("stop_val", cnt, 5);
    chk_rd("stop_stat", 2'd3, 8'h00);
    step(); step();
    check("stop_hold", cnt, 5);

    // Start during RUN restarts through CLEAR
    wr(2'd0, 8'h01);
    step(); step();
    check("rs_run_val", cnt, 1);
    wr(2'd0, 8'h01);
    check("rs_clear", cnt_clear, 1);
    check("rs_busy", busy, 1);
    step();
    check("rs_val0", cnt, 0);
    check("rs_en", cnt_enable, 1);
    wr(2'd0, 8'h04);

    // Match coinciding with STATUS clear: set wins
    wr(2'd2, 8'd2);
    wr(2'd0, 8'h01);
    step(); step(); step();
    check("col_match", cnt_clear, 1);
    wr(2'd3, 8'h02);
    chk_rd("col_stat", 2'd3, 8'h02);

    // Start and stop together: stop wins
    wr(2'd2, 8'd10);
    wr(2'd0, 8'h01);
    step();
    check("ss_running", busy, 1);
    wr(2'd0, 8'h05);
    check("ss_busy", busy, 0);
    check("ss_en", cnt_enable, 0);
    wr(2'd0, 8'h05);
    check("ss_idle_busy", busy, 0);

    // Asynchronous reset mid-RUN
    wr(2'd0, 8'h0B);
    step(); step(); step();
    check("ar_pre_irq", irq, 1);
    check("ar_pre_en", cnt_enable, 1);
    check("ar_pre_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_en", cnt_enable, 0);
    check("ar_busy", busy, 0);
    check("ar_irq", irq, 0);
    check("ar_clr", cnt_clear, 0);
    chk_rd("ar_cmp", 2'd2, 8'hFF);
    chk_rd("ar_stat", 2'd3, 8'h00);
    step();
    reset = 1'b1;
    step(); step();
    check("ar_post_busy", busy, 0);
    check("ar_post_en", cnt_enable, 0);
    chk_rd("ar_post_ctrl", 2'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
